vga_timing_gen: RTL and testbench

- Produces the raster scan that the pixel-generation logic consumes: pixel coordinates x/y, frame_active, h_sync and v_sync, plus line/frame strobes and a frame counter.
- Runs in the pixel clock domain. Advances one pixel per cycle when the pixel enable ce is high.
- Sync outputs drive the VGA connector directly. x, y, frame_active and v_sync feed the graphics engine.
- Default timing is 640x480@60 (25.175/25.2 MHz pixel clock).

---
 rtl/vga_timing_pkg.sv | 22 ++
 rtl/vga_timing_gen_wrap_counter.sv | 24 ++
 rtl/vga_timing_gen.sv | 96 +++++++++
 tb/tb_vga_timing_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and derived-value helpers
package vga_timing_pkg;
  localparam int CW = 10;
  localparam int MAX_TOTAL = 1 << CW;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FRONT_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BACK_D = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FRONT_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BACK_D = 33;
  function automatic int total(input int act, input int fp, input int sw, input int bp);
    return act + fp + sw + bp;
  endfunction
  function automatic int sync_start(input int act, input int fp);
    return act + fp;
  endfunction
  function automatic int sync_end(input int act, input int fp, input int sw);
    return act + fp + sw;
  endfunction
endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter: modulo counter with enable, sync reset to its last state and a wrap pulse
module wrap_counter
  import vga_timing_pkg::*;
#(
  parameter int MOD = H_ACTIVE_D + H_FRONT_D + H_SYNC_D + H_BACK_D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic [CW-1:0] o_next,
  output logic          o_wrap
);
  localparam logic [CW-1:0] MAX = CW'(MOD - 1);
  logic [CW-1:0] r_cnt;
  // next value includes reset so downstream decode always sees what the register will hold
  always_comb begin
    o_wrap = rst_n && i_en && (r_cnt == MAX);
    o_next = !rst_n ? MAX : !i_en ? r_cnt : (r_cnt == MAX) ? '0 : r_cnt + 1'b1;
  end
  // count register
  always_ff @(posedge clk) r_cnt <= o_next;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster scan position, syncs, strobes and frame counter, all registered
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FRONT = H_FRONT_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BACK = H_BACK_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FRONT = V_FRONT_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BACK = V_BACK_D,
  parameter bit H_SYNC_POL = 1'b0,
  parameter bit V_SYNC_POL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_active,
  output logic          h_sync,
  output logic          v_sync,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_count
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam int HS_START = sync_start(H_ACTIVE, H_FRONT);
  localparam int HS_END = sync_end(H_ACTIVE, H_FRONT, H_SYNC);
  localparam int VS_START = sync_start(V_ACTIVE, V_FRONT);
  localparam int VS_END = sync_end(V_ACTIVE, V_FRONT, V_SYNC);
  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_size_check
    $error("vga_timing_gen: line or frame total exceeds coordinate range");
  end
  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic          r_active;
  logic          r_hs;
  logic          r_vs;
  logic          r_ls;
  logic          r_fs;
  logic [7:0]    r_fc;
  wrap_counter #(.MOD(H_TOTAL)) u_h (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (ce),
    .o_cnt (x),
    .o_next(w_h_next),
    .o_wrap(w_h_wrap)
  );
  wrap_counter #(.MOD(V_TOTAL)) u_v (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_h_wrap),
    .o_cnt (y),
    .o_next(w_v_next),
    .o_wrap(w_v_wrap)
  );
  // decode of the position the counters are about to present
  always_comb begin
    w_active = int'(w_h_next) < H_ACTIVE && int'(w_v_next) < V_ACTIVE;
    w_hs = int'(w_h_next) >= HS_START && int'(w_h_next) < HS_END;
    w_vs = int'(w_v_next) >= VS_START && int'(w_v_next) < VS_END;
  end
  // flags load alongside the position; strobes follow the wrap pulses so they drop when ce is low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_hs     <= ~H_SYNC_POL;
      r_vs     <= ~V_SYNC_POL;
      r_ls     <= 1'b0;
      r_fs     <= 1'b0;
      r_fc     <= '0;
    end else begin
      r_active <= w_active;
      r_hs     <= w_hs ? H_SYNC_POL : ~H_SYNC_POL;
      r_vs     <= w_vs ? V_SYNC_POL : ~V_SYNC_POL;
      r_ls     <= w_h_wrap;
      r_fs     <= w_v_wrap;
      r_fc     <= r_fc + {7'd0, w_v_wrap};
    end
  end
  assign frame_active = r_active;
  assign h_sync = r_hs;
  assign v_sync = r_vs;
  assign line_start = r_ls;
  assign frame_start = r_fs;
  assign frame_count = r_fc;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default, positive-polarity and small-timing builds
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic fa0, hs0, vs0, ls0, fs0, fa1, hs1, vs1, ls1, fs1, fa2, hs2, vs2, ls2, fs2;
  logic [7:0] fc0, fc1, fc2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  vga_timing_gen d0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x0), .y(y0), .frame_active(fa0), .h_sync(hs0),
    .v_sync(vs0), .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
  );
  vga_timing_gen #(.H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x1), .y(y1), .frame_active(fa1), .h_sync(hs1),
    .v_sync(vs1), .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
  );
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) d2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .x(x2), .y(y2), .frame_active(fa2), .h_sync(hs2),
    .v_sync(vs2), .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int bad, n_fa, n_hs, n_hs1, n_ls, n_fs, n_vs, ex, ey, px, py;
    logic [7:0] fc_a, fc_b, fc_c, fc_d;
    rst_n = 1'b0;
    ce = 1'b1;
    tick(2);
    chk("rst_x", x0, 799);
    chk("rst_y", y0, 524);
    chk("rst_active", fa0, 0);
    chk("rst_hs", hs0, 1);
    chk("rst_vs", vs0, 1);
    chk("rst_ls", ls0, 0);
    chk("rst_fs", fs0, 0);
    chk("rst_fc", fc0, 0);
    chk("rst_hs_pos", hs1, 0);
    chk("rst_vs_pos", vs1, 0);
    chk("rst_small_x", x2, 14);
    chk("rst_small_y", y2, 7);
    rst_n = 1'b1;
    tick(1);
    chk("first_x", x0, 0);
    chk("first_y", y0, 0);
    chk("first_active", fa0, 1);
    chk("first_fs", fs0, 1);
    chk("first_ls", ls0, 1);
    chk("first_fc", fc0, 1);
    chk("first_hs_pos", hs1, 0);
    bad = 0; n_fa = 0; n_hs = 0; n_hs1 = 0; n_ls = 0;
    for (int i = 0; i < 800; i++) begin
      if (x0 !== 10'(i) || y0 !== 10'd0) bad++;
      if (hs0 !== !(i >= 656 && i <= 751)) bad++;
      if (hs1 !== (i >= 656 && i <= 751)) bad++;
      if (fa0 !== (i < 640)) bad++;
      n_fa += int'(fa0);
      n_hs += int'(!hs0);
      n_hs1 += int'(hs1);
      n_ls += int'(ls0);
      tick(1);
    end
    chk("line_bad", bad, 0);
    chk("line_active_clks", n_fa, 640);
    chk("line_hs_low_clks", n_hs, 96);
    chk("line_hs_pos_high_clks", n_hs1, 96);
    chk("line_ls_count", n_ls, 1);
    chk("line2_x", x0, 0);
    chk("line2_y", y0, 1);
    chk("line2_ls", ls0, 1);
    chk("line2_fs", fs0, 0);
    ce = 1'b0;
    tick(3);
    chk("hold_x", x0, 0);
    chk("hold_y", y0, 1);
    chk("hold_ls", ls0, 0);
    chk("hold_active", fa0, 1);
    chk("hold_fc", fc0, 1);
    ce = 1'b1;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    ex = 0; ey = 0; bad = 0; n_fs = 0; n_vs = 0;
    fc_a = '0; fc_b = '0; fc_c = '0; fc_d = '0;
    for (int t = 0; t <= 255 * 120; t++) begin
      if (x2 !== 10'(ex) || y2 !== 10'(ey)) bad++;
      if (vs2 !== !(ey == 5 || ey == 6)) bad++;
      if (hs2 !== !(ex >= 10 && ex <= 12)) bad++;
      if (fa2 !== (ex < 8 && ey < 4)) bad++;
      if (fs2 !== (t % 120 == 0)) bad++;
      if (ls2 !== (ex == 0)) bad++;
      if (t < 120 && !vs2) n_vs++;
      n_fs += int'(fs2);
      if (t == 120) fc_a = fc2;
      if (t == 240) fc_b = fc2;
      if (t == 254 * 120) fc_c = fc2;
      if (t == 255 * 120) fc_d = fc2;
      if (t < 255 * 120) begin
        tick(1);
        ex = (ex == 14) ? 0 : ex + 1;
        if (ex == 0) ey = (ey == 7) ? 0 : ey + 1;
      end
    end
    chk("frame_bad", bad, 0);
    chk("frame_vs_low_clks", n_vs, 30);
    chk("frame_fs_count", n_fs, 256);
    chk("frame_fc_2", fc_a, 2);
    chk("frame_fc_3", fc_b, 3);
    chk("frame_fc_255", fc_c, 255);
    chk("frame_fc_wrap", fc_d, 0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    bad = 0; n_fs = 0; n_ls = 0;
    for (int i = 0; i < 120; i++) begin
      px = int'(x2);
      py = int'(y2);
      ce = 1'b0;
      tick(1);
      if (x2 !== 10'(px) || y2 !== 10'(py) || fs2 !== 1'b0 || ls2 !== 1'b0) bad++;
      ce = 1'b1;
      tick(1);
      n_fs += int'(fs2);
      n_ls += int'(ls2);
    end
    chk("alt_bad", bad, 0);
    chk("alt_fs_count", n_fs, 1);
    chk("alt_ls_count", n_ls, 8);
    chk("alt_x", x2, 0);
    chk("alt_y", y2, 0);
    chk("alt_fs", fs2, 1);
    chk("alt_fc", fc2, 2);
    tick(50);
    chk("mid_x", x2, 5);
    chk("mid_y", y2, 3);
    rst_n = 1'b0;
    tick(1);
    chk("mid_rst_x", x2, 14);
    chk("mid_rst_y", y2, 7);
    chk("mid_rst_fs", fs2, 0);
    chk("mid_rst_fc", fc2, 0);
    chk("mid_rst_hs", hs2, 1);
    chk("mid_rst_vs", vs2, 1);
    chk("mid_rst_x0", x0, 799);
    chk("mid_rst_y0", y0, 524);
    rst_n = 1'b1;
    ce = 1'b0;
    tick(2);
    chk("mid_hold_x", x2, 14);
    chk("mid_hold_fs", fs2, 0);
    ce = 1'b1;
    tick(1);
    chk("restart_x", x2, 0);
    chk("restart_y", y2, 0);
    chk("restart_fs", fs2, 1);
    chk("restart_fc", fc2, 1);
    chk("restart_x0", x0, 0);
    chk("restart_fs0", fs0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
